// File: rtl/j1_io_pkg.sv
// Shared register offsets, status bit positions and FSM state types for the j1 I/O UART.
package j1_io_pkg;

  localparam int DATA_OFS   = 0;
  localparam int STATUS_OFS = 1;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_IDLE  = 1;
  localparam int ST_RX_VALID = 2;
  localparam int ST_RX_OVR   = 3;
  localparam int ST_RX_FERR  = 4;
  localparam int ST_TX_DROP  = 5;
  localparam int ST_LOOPBACK = 15;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/j1_io_fifo.sv
// Synchronous FIFO with full/empty flags; a push while full is accepted when a pop
// happens on the same edge.
module j1_io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/j1_io_uart.sv
// Memory-mapped 8N1 UART responder for the j1 I/O bus (DATA at BASE_ADDR, STATUS at +1).
// Optional internal loopback when J1_IO_UART_LOOPBACK_EN is defined.
import j1_io_pkg::*;

module j1_io_uart #(
  parameter logic [15:0] BASE_ADDR = 16'h2000,
  parameter int          CLK_DIV   = 434,
  parameter int          TX_DEPTH  = 16
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_wdata,
  output logic [15:0] io_rdata,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam logic [15:0] DATA_ADDR = BASE_ADDR + 16'(DATA_OFS);
  localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'(STATUS_OFS);
  localparam int          CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BIT_END  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);

  logic sel_data, sel_stat, wr_data, rd_data, rd_stat;
  assign sel_data = (io_addr == DATA_ADDR);
  assign sel_stat = (io_addr == STAT_ADDR);
  assign wr_data  = io_wr && sel_data;
  assign rd_data  = io_rd && sel_data;
  assign rd_stat  = io_rd && sel_stat;

  logic       fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;

  j1_io_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (sys_clk_i),
    .srst  (sys_rst_i),
    .push  (wr_data),
    .wdata (io_wdata[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  tx_state_t     tx_state_reg, tx_state_next;
  logic [CW-1:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0]    tx_bit_reg, tx_bit_next;
  logic [7:0]    tx_shift_reg, tx_shift_next;
  logic          tx_line_reg, tx_line_next;

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg + CW'(1);
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    tx_line_next  = tx_line_reg;
    fifo_pop      = 1'b0;
    case (tx_state_reg)
      TX_IDLE: begin
        tx_cnt_next = '0;
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          tx_shift_next = fifo_rdata;
          tx_line_next  = 1'b0;
          tx_state_next = TX_START;
        end
      end
      TX_START: if (tx_cnt_reg == BIT_END) begin
        tx_cnt_next   = '0;
        tx_bit_next   = '0;
        tx_line_next  = tx_shift_reg[0];
        tx_state_next = TX_DATA;
      end
      TX_DATA: if (tx_cnt_reg == BIT_END) begin
        tx_cnt_next   = '0;
        tx_shift_next = tx_shift_reg >> 1;
        if (tx_bit_reg == 3'd7) begin
          tx_line_next  = 1'b1;
          tx_state_next = TX_STOP;
        end else begin
          tx_bit_next  = tx_bit_reg + 3'd1;
          tx_line_next = tx_shift_reg[1];
        end
      end
      TX_STOP: if (tx_cnt_reg == BIT_END) begin
        tx_cnt_next = '0;
        // Chain straight into the next start bit so queued bytes leave with no idle gap.
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          tx_shift_next = fifo_rdata;
          tx_line_next  = 1'b0;
          tx_state_next = TX_START;
        end else begin
          tx_line_next  = 1'b1;
          tx_state_next = TX_IDLE;
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_line_reg  <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      tx_line_reg  <= tx_line_next;
    end
  end

  assign uart_tx = tx_line_reg;

  logic rx_src;
`ifdef J1_IO_UART_LOOPBACK_EN
  logic loopback_reg;
  logic unused_wdata;
  assign unused_wdata = ^io_wdata[14:8];
  assign rx_src = loopback_reg ? tx_line_reg : uart_rx;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i)             loopback_reg <= 1'b0;
    else if (io_wr && sel_stat) loopback_reg <= io_wdata[15];
  end
`else
  logic unused_wdata;
  assign unused_wdata = ^io_wdata[15:8];
  assign rx_src = uart_rx;
`endif

  logic [1:0] rx_sync_reg;
  logic       rx_s;
  assign rx_s = rx_sync_reg[1];

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) rx_sync_reg <= 2'b11;
    else           rx_sync_reg <= {rx_sync_reg[0], rx_src};
  end

  rx_state_t     rx_state_reg, rx_state_next;
  logic [CW-1:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0]    rx_bit_reg, rx_bit_next;
  logic [7:0]    rx_shift_reg, rx_shift_next;
  logic          rx_load, rx_ferr_set;

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg + CW'(1);
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_load       = 1'b0;
    rx_ferr_set   = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        rx_cnt_next = '0;
        if (!rx_s) rx_state_next = RX_START;
      end
      // Half-bit wait lands subsequent samples near the centre of each bit.
      RX_START: if (rx_cnt_reg == HALF_END) begin
        rx_cnt_next   = '0;
        rx_bit_next   = '0;
        rx_state_next = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_reg == BIT_END) begin
        rx_cnt_next   = '0;
        rx_shift_next = {rx_s, rx_shift_reg[7:1]};
        if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
        else                    rx_bit_next   = rx_bit_reg + 3'd1;
      end
      RX_STOP: if (rx_cnt_reg == BIT_END) begin
        rx_cnt_next   = '0;
        rx_state_next = RX_IDLE;
        rx_load       = rx_s;
        rx_ferr_set   = !rx_s;
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
    end
  end

  logic       rx_valid_reg, rx_overrun_reg, rx_ferr_reg, tx_drop_reg;
  logic [7:0] rx_byte_reg;

  // Sticky flags: a new event on the same edge as a STATUS read is kept, not lost.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rx_valid_reg   <= 1'b0;
      rx_overrun_reg <= 1'b0;
      rx_ferr_reg    <= 1'b0;
      tx_drop_reg    <= 1'b0;
      rx_byte_reg    <= '0;
    end else begin
      if (rx_load) rx_byte_reg <= rx_shift_reg;
      if (rx_load)      rx_valid_reg <= 1'b1;
      else if (rd_data) rx_valid_reg <= 1'b0;
      rx_overrun_reg <= (rx_overrun_reg && !rd_stat) || (rx_load && rx_valid_reg && !rd_data);
      rx_ferr_reg    <= (rx_ferr_reg && !rd_stat) || rx_ferr_set;
      tx_drop_reg    <= (tx_drop_reg && !rd_stat) || (wr_data && fifo_full && !fifo_pop);
    end
  end

  always_comb begin
    io_rdata = '0;
    if (sel_data) begin
      io_rdata = {7'b0, rx_valid_reg, rx_byte_reg};
    end else if (sel_stat) begin
      io_rdata[ST_TX_FULL]  = fifo_full;
      io_rdata[ST_TX_IDLE]  = fifo_empty && (tx_state_reg == TX_IDLE);
      io_rdata[ST_RX_VALID] = rx_valid_reg;
      io_rdata[ST_RX_OVR]   = rx_overrun_reg;
      io_rdata[ST_RX_FERR]  = rx_ferr_reg;
      io_rdata[ST_TX_DROP]  = tx_drop_reg;
`ifdef J1_IO_UART_LOOPBACK_EN
      io_rdata[ST_LOOPBACK] = loopback_reg;
`endif
    end
  end

endmodule

// File: tb/tb_j1_io_uart.sv
// Self-checking bench for j1_io_uart: transaction-level register model plus line-waveform model.
module tb_j1_io_uart;

  localparam int          CLK_DIV  = 8;
  localparam int          TX_DEPTH = 4;
  localparam logic [15:0] BASE     = 16'h2000;
  localparam logic [15:0] STAT     = BASE + 16'd1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_rd = 1'b0;
  logic        io_wr = 1'b0;
  logic [15:0] io_addr = 16'h0;
  logic [15:0] io_wdata = 16'h0;
  logic [15:0] io_rdata;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  int checks = 0;
  int errors = 0;

  bit line_q[$];

  logic       exp_valid = 1'b0;
  logic       exp_ovr   = 1'b0;
  logic       exp_ferr  = 1'b0;
  logic       exp_drop  = 1'b0;
  logic       exp_loop  = 1'b0;
  logic [7:0] exp_byte  = 8'h0;

  j1_io_uart #(.BASE_ADDR(BASE), .CLK_DIV(CLK_DIV), .TX_DEPTH(TX_DEPTH)) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .io_rd     (io_rd),
    .io_wr     (io_wr),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .uart_tx   (uart_tx),
    .uart_rx   (uart_rx)
  );

  always #5 clk = ~clk;

  // One line sample per cycle, taken between active edges.
  always @(negedge clk) line_q.push_back(uart_tx);

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  function automatic bit frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  function automatic logic [15:0] exp_status(input logic idle, input logic full);
    return {exp_loop, 9'b0, exp_drop, exp_ferr, exp_ovr, exp_valid, idle, full};
  endfunction

  task automatic model_reset();
    exp_valid = 0; exp_ovr = 0; exp_ferr = 0; exp_drop = 0; exp_loop = 0; exp_byte = 8'h0;
  endtask

  task automatic model_rx(input logic [7:0] b, input logic stop);
    if (stop) begin
      if (exp_valid) exp_ovr = 1'b1;
      exp_valid = 1'b1;
      exp_byte  = b;
    end else begin
      exp_ferr = 1'b1;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset(output int idx);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); idx = line_q.size();
    @(negedge clk); rst = 1'b0;
    model_reset();
    $display("reset");
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data, output int idx);
    @(negedge clk); io_wr = 1'b1; io_addr = addr; io_wdata = data;
    @(posedge clk); idx = line_q.size();
    #1 io_wr = 1'b0; io_addr = 16'h0;
    $display("write addr=%h data=%h", addr, data);
  endtask

  task automatic do_read(input logic [15:0] addr, output logic [15:0] data);
    @(negedge clk); io_rd = 1'b1; io_addr = addr;
    #1 data = io_rdata;
    @(posedge clk);
    #1 io_rd = 1'b0; io_addr = 16'h0;
    if (addr == BASE) exp_valid = 1'b0;
    else if (addr == STAT) begin exp_ovr = 0; exp_ferr = 0; exp_drop = 0; end
    $display("read  addr=%h data=%h", addr, data);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); uart_rx = (k == 9) ? stop : frame_bit(b, k);
      repeat (CLK_DIV - 1) @(negedge clk);
    end
    @(negedge clk); uart_rx = 1'b1;
    model_rx(b, stop);
    $display("rx frame byte=%h stop=%b", b, stop);
  endtask

  task automatic test_reset();
    logic [15:0] rd;
    int idx, zeros;
    rst = 1'b1;
    wait_cycles(3);
    @(negedge clk); rst = 1'b0;
    model_reset();
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
    do_read(BASE, rd);
    checks++;
    if (rd !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", rd); end
    do_read(16'h0000, rd);
    checks++;
    if (rd !== 16'h0000) begin errors++; $display("FAIL unmapped_read: got %h expected 0000", rd); end
    idx = line_q.size();
    wait_cycles(100);
    zeros = 0;
    for (int i = 0; i < 100; i++) if (line_q[idx+i] !== 1'b1) zeros++;
    checks++;
    if (zeros != 0) begin errors++; $display("FAIL idle_line: got %0d low samples expected 0", zeros); end
    do_read(STAT, rd);
    checks++;
    if (rd !== 16'h0002) begin errors++; $display("FAIL reset_status: got %h expected 0002", rd); end
  endtask

  task automatic test_tx_single();
    logic [7:0]  b;
    logic [15:0] rd;
    int idx, s, bad;
    for (int t = 0; t < 4; t++) begin
      b = (t == 0) ? 8'h41 : 8'($urandom);
      do_write(BASE, {8'($urandom), b}, idx);
      wait_cycles(90);
      checks++;
      if (line_q[idx] !== 1'b1 || line_q[idx+1] !== 1'b0) begin
        errors++;
        $display("FAIL tx_latency: got %b,%b expected 1,0", line_q[idx], line_q[idx+1]);
      end
      s = idx + 1;
      for (int k = 0; k < 10; k++) begin
        bad = 0;
        for (int j = 0; j < CLK_DIV; j++)
          if (line_q[s + CLK_DIV*k + j] !== frame_bit(b, k)) bad++;
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL tx_bit byte=%h bit=%0d: got %0d wrong samples expected level %b", b, k, bad, frame_bit(b, k));
        end
      end
      do_read(STAT, rd);
      checks++;
      if (rd !== exp_status(1'b1, 1'b0)) begin errors++; $display("FAIL tx_done_status: got %h expected %h", rd, exp_status(1'b1, 1'b0)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  b [6];
    logic [15:0] rd;
    int idx0, idx, s, bad, lows;
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    do_write(BASE, {8'h00, b[0]}, idx0);
    for (int i = 1; i < TX_DEPTH + 1; i++) do_write(BASE, {8'h00, b[i]}, idx);
    do_read(STAT, rd);
    checks++;
    if (rd !== exp_status(1'b0, 1'b1)) begin errors++; $display("FAIL full_status: got %h expected %h", rd, exp_status(1'b0, 1'b1)); end
    do_write(BASE, {8'h00, b[5]}, idx);
    exp_drop = 1'b1;
    do_read(STAT, rd);
    checks++;
    if (rd !== {10'b0, 1'b1, 5'b00001}) begin errors++; $display("FAIL drop_status: got %h expected 0021", rd); end
    do_read(STAT, rd);
    checks++;
    if (rd !== exp_status(1'b0, 1'b1)) begin errors++; $display("FAIL drop_cleared: got %h expected %h", rd, exp_status(1'b0, 1'b1)); end
    wait_cycles((TX_DEPTH + 1) * 10 * CLK_DIV + 40);
    // The first byte leaves immediately, so TX_DEPTH+1 bytes fit; frames are contiguous.
    for (int f = 0; f < TX_DEPTH + 1; f++) begin
      s = idx0 + 1 + f * 10 * CLK_DIV;
      bad = 0;
      for (int k = 0; k < 10; k++)
        for (int j = 0; j < CLK_DIV; j++)
          if (line_q[s + CLK_DIV*k + j] !== frame_bit(b[f], k)) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL b2b_frame %0d byte=%h: got %0d wrong samples expected 0", f, b[f], bad); end
    end
    s = idx0 + 1 + (TX_DEPTH + 1) * 10 * CLK_DIV;
    lows = 0;
    for (int i = 0; i < 30; i++) if (line_q[s+i] !== 1'b1) lows++;
    checks++;
    if (lows != 0) begin errors++; $display("FAIL b2b_extra_frame: got %0d low samples expected 0", lows); end
    do_read(STAT, rd);
    checks++;
    if (rd !== exp_status(1'b1, 1'b0)) begin errors++; $display("FAIL b2b_final_status: got %h expected %h", rd, exp_status(1'b1, 1'b0)); end
  endtask

  task automatic test_rx();
    logic [7:0]  b;
    logic [15:0] rd, want;
    for (int t = 0; t < 4; t++) begin
      b = (t == 0) ? 8'h5A : 8'($urandom);
      send_frame(b, 1'b1);
      wait_cycles(10);
      want = {7'b0, exp_valid, exp_byte};
      do_read(BASE, rd);
      checks++;
      if (rd !== want) begin errors++; $display("FAIL rx_data: got %h expected %h", rd, want); end
      want = {7'b0, exp_valid, exp_byte};
      do_read(BASE, rd);
      checks++;
      if (rd !== want) begin errors++; $display("FAIL rx_data_reread: got %h expected %h", rd, want); end
    end
    @(negedge clk); uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    $display("rx glitch 3 cycles");
    wait_cycles(30);
    want = exp_status(1'b1, 1'b0);
    do_read(STAT, rd);
    checks++;
    if (rd !== want) begin errors++; $display("FAIL glitch_status: got %h expected %h", rd, want); end
    want = {7'b0, exp_valid, exp_byte};
    do_read(BASE, rd);
    checks++;
    if (rd !== want) begin errors++; $display("FAIL glitch_data: got %h expected %h", rd, want); end
  endtask

  task automatic test_rx_errors();
    logic [7:0]  b1, b2;
    logic [15:0] rd, want;
    for (int t = 0; t < 2; t++) begin
      b1 = (t == 0) ? 8'h11 : 8'($urandom);
      b2 = (t == 0) ? 8'h22 : 8'($urandom);
      send_frame(b1, 1'b1);
      send_frame(b2, 1'b1);
      wait_cycles(10);
      want = exp_status(1'b1, 1'b0);
      do_read(STAT, rd);
      checks++;
      if (rd !== want) begin errors++; $display("FAIL overrun_status: got %h expected %h", rd, want); end
      want = {7'b0, exp_valid, exp_byte};
      do_read(BASE, rd);
      checks++;
      if (rd !== want) begin errors++; $display("FAIL overrun_data: got %h expected %h", rd, want); end
      // t==0: framing error with nothing held; t==1: with a valid byte held.
      if (t == 1) send_frame(8'($urandom), 1'b1);
      send_frame(8'($urandom), 1'b0);
      wait_cycles(20);
      want = exp_status(1'b1, 1'b0);
      do_read(STAT, rd);
      checks++;
      if (rd !== want) begin errors++; $display("FAIL ferr_status: got %h expected %h", rd, want); end
      want = {7'b0, exp_valid, exp_byte};
      do_read(BASE, rd);
      checks++;
      if (rd !== want) begin errors++; $display("FAIL ferr_data: got %h expected %h", rd, want); end
    end
  endtask

`ifdef J1_IO_UART_LOOPBACK_EN
  task automatic test_loopback();
    logic [15:0] rd, want;
    int idx;
    do_write(STAT, 16'h8000, idx);
    exp_loop = 1'b1;
    @(negedge clk); uart_rx = 1'b0;
    do_write(BASE, 16'h00C3, idx);
    wait_cycles(100);
    model_rx(8'hC3, 1'b1);
    want = exp_status(1'b1, 1'b0);
    do_read(STAT, rd);
    checks++;
    if (rd !== want) begin errors++; $display("FAIL loop_status: got %h expected %h", rd, want); end
    do_read(BASE, rd);
    checks++;
    if (rd !== 16'h01C3) begin errors++; $display("FAIL loop_data: got %h expected 01C3", rd); end
    @(negedge clk); uart_rx = 1'b1;
    do_write(STAT, 16'h0000, idx);
    exp_loop = 1'b0;
    do_read(STAT, rd);
    checks++;
    if (rd !== exp_status(1'b1, 1'b0)) begin errors++; $display("FAIL loop_off_status: got %h expected %h", rd, exp_status(1'b1, 1'b0)); end
  endtask
`else
  task automatic test_status_write();
    logic [15:0] rd;
    int idx;
    do_write(STAT, 16'h8000 | 16'($urandom_range(0, 255)), idx);
    wait_cycles(4);
    do_read(STAT, rd);
    checks++;
    if (rd !== exp_status(1'b1, 1'b0)) begin errors++; $display("FAIL status_write_ignored: got %h expected %h", rd, exp_status(1'b1, 1'b0)); end
  endtask
`endif

  task automatic test_reset_midframe();
    logic [15:0] rd;
    int idx, ridx, lows;
    do_write(BASE, {8'h00, 8'($urandom_range(0, 127))}, idx);
    do_write(BASE, {8'h00, 8'($urandom)}, idx);
    wait_cycles(20);
    do_reset(ridx);
    wait_cycles(100);
    lows = 0;
    for (int i = 0; i < 100; i++) if (line_q[ridx+i] !== 1'b1) lows++;
    checks++;
    if (lows != 0) begin errors++; $display("FAIL midframe_reset_line: got %0d low samples expected 0", lows); end
    do_read(STAT, rd);
    checks++;
    if (rd !== 16'h0002) begin errors++; $display("FAIL midframe_reset_status: got %h expected 0002", rd); end
    do_read(BASE, rd);
    checks++;
    if (rd !== 16'h0000) begin errors++; $display("FAIL midframe_reset_data: got %h expected 0000", rd); end
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_back_to_back();
    test_rx();
    test_rx_errors();
`ifdef J1_IO_UART_LOOPBACK_EN
    test_loopback();
`else
    test_status_write();
`endif
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
